// File: rtl/average_regulator_pkg.sv
// Shared constants for the average filter / PWM on-time regulator.
// State codes are plain localparams so older blocks can share the encoding.
package average_regulator_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_DISCARD = 3'd2;
  localparam logic [2:0] ST_ACCUM   = 3'd3;
  localparam logic [2:0] ST_DECIDE  = 3'd4;

  localparam int DEF_SETTLE_CYC = 250;
  localparam int DEF_TON_INIT   = 450;
  localparam int DEF_TON_MIN    = 10;
  localparam int DEF_TON_MAX    = 460;

endpackage

// File: rtl/sat_step_clamp.sv
// Combinational on-time stepper: +/-STEP with saturation into [TON_MIN, TON_MAX].
// Work is done one bit wider than the register so a step can never wrap.
module sat_step_clamp
  import average_regulator_pkg::*;
#(
  parameter int TON_W   = 10,
  parameter int STEP    = 1,
  parameter int TON_MIN = DEF_TON_MIN,
  parameter int TON_MAX = DEF_TON_MAX
) (
  input  logic [TON_W-1:0] time_on,
  input  logic             inc,
  input  logic             dec,
  output logic [TON_W-1:0] time_on_next
);

  localparam logic [TON_W:0] STEP_X = (TON_W+1)'(STEP);
  localparam logic [TON_W:0] MIN_X  = (TON_W+1)'(TON_MIN);
  localparam logic [TON_W:0] MAX_X  = (TON_W+1)'(TON_MAX);

  logic [TON_W:0] cur;
  logic [TON_W:0] up;
  logic [TON_W:0] down;

  always_comb begin
    cur          = {1'b0, time_on};
    up           = cur + STEP_X;
    down         = cur - STEP_X;
    time_on_next = time_on;
    if (inc) begin
      time_on_next = (up > MAX_X) ? TON_W'(MAX_X) : TON_W'(up);
    end else if (dec) begin
      // Compare before subtracting so an underflow is never selected
      time_on_next = (cur < MIN_X + STEP_X) ? TON_W'(MIN_X) : TON_W'(down);
    end
  end

endmodule

// File: rtl/average_regulator.sv
// Averages qualified ADC samples and nudges the PWM on-time toward the
// [v_min_in, v_max_in] band, with lock detection and inverted-band flagging.
module average_regulator
  import average_regulator_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int TON_W      = 10,
  parameter int LOG2_N     = 2,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DISCARD    = 1,
  parameter int STEP       = 1,
  parameter int TON_INIT   = DEF_TON_INIT,
  parameter int TON_MIN    = DEF_TON_MIN,
  parameter int TON_MAX    = DEF_TON_MAX,
  parameter int LOCK_CNT   = 8
) (
  input  logic             clk_1M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] v_in,
  input  logic [ADC_W-1:0] v_max_in,
  input  logic [ADC_W-1:0] v_min_in,
  output logic [ADC_W-1:0] v_ave,
  output logic             ave_valid,
  output logic [TON_W-1:0] time_on,
  output logic             locked,
  output logic             band_err
);

  localparam int N      = 1 << LOG2_N;
  localparam int SUM_W  = ADC_W + LOG2_N;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int DISC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int ACC_W  = LOG2_N + 1;
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [DISC_W-1:0] DISC_LAST   = DISC_W'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [ACC_W-1:0]  ACC_LAST    = ACC_W'(N - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_CNT);
  localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_CNT - 1);
  localparam logic [2:0]        WINDOW_START = (DISCARD > 0) ? ST_DISCARD : ST_ACCUM;

  logic [2:0]        state;
  logic [SET_W-1:0]  settle_cnt;
  logic [DISC_W-1:0] disc_cnt;
  logic [ACC_W-1:0]  acc_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [SUM_W-1:0]  sum;
  logic [ADC_W-1:0]  avg;
  logic              inverted;
  logic              too_low;
  logic              too_high;
  logic [TON_W-1:0]  time_on_next;

  assign avg      = ADC_W'(sum >> LOG2_N);
  assign inverted = v_min_in > v_max_in;
  assign too_low  = avg < v_min_in;
  assign too_high = avg > v_max_in;

  sat_step_clamp #(
    .TON_W  (TON_W),
    .STEP   (STEP),
    .TON_MIN(TON_MIN),
    .TON_MAX(TON_MAX)
  ) u_clamp (
    .time_on     (time_on),
    .inc         (too_low),
    .dec         (too_high),
    .time_on_next(time_on_next)
  );

  // Dropping en aborts whatever is in flight but keeps the last command
  always_ff @(posedge clk_1M) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      disc_cnt   <= '0;
      acc_cnt    <= '0;
      lock_cnt   <= '0;
      sum        <= '0;
      v_ave      <= '0;
      ave_valid  <= 1'b0;
      time_on    <= TON_W'(TON_INIT);
      locked     <= 1'b0;
      band_err   <= 1'b0;
    end else if (!en) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      disc_cnt   <= '0;
      acc_cnt    <= '0;
      lock_cnt   <= '0;
      sum        <= '0;
      ave_valid  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      ave_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= WINDOW_START;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_DISCARD: begin
          sum <= '0;
          if (sample_valid) begin
            if (disc_cnt == DISC_LAST) begin
              state    <= ST_ACCUM;
              disc_cnt <= '0;
            end else begin
              disc_cnt <= disc_cnt + DISC_W'(1);
            end
          end
        end
        ST_ACCUM: begin
          if (sample_valid) begin
            sum <= sum + SUM_W'(v_in);
            if (acc_cnt == ACC_LAST) begin
              state   <= ST_DECIDE;
              acc_cnt <= '0;
            end else begin
              acc_cnt <= acc_cnt + ACC_W'(1);
            end
          end
        end
        ST_DECIDE: begin
          v_ave     <= avg;
          ave_valid <= 1'b1;
          band_err  <= inverted;
          sum       <= '0;
          state     <= WINDOW_START;
          if (inverted || too_low || too_high) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
            if (!inverted) begin
              time_on <= time_on_next;
            end
          end else begin
            if (lock_cnt != LOCK_MAX) begin
              lock_cnt <= lock_cnt + LOCK_W'(1);
            end
            locked <= (lock_cnt >= LOCK_LAST);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_average_regulator.sv
// Self-checking bench: directed scenarios plus a random phase, all outputs
// compared every cycle against a sample-queue reference model.
`timescale 1ns/1ps
module tb_average_regulator;

  localparam int ADC_W      = 12;
  localparam int TON_W      = 10;
  localparam int LOG2_N     = 2;
  localparam int N          = 4;
  localparam int SETTLE_CYC = 250;
  localparam int DISCARD    = 1;
  localparam int STEP       = 1;
  localparam int TON_INIT   = 450;
  localparam int TON_MIN    = 10;
  localparam int TON_MAX    = 460;
  localparam int LOCK_CNT   = 8;
  localparam int FIRST_AVG_LATENCY = 1 + SETTLE_CYC + DISCARD + N + 1;

  logic             clk_1M = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sample_valid = 1'b0;
  logic [ADC_W-1:0] v_in = '0;
  logic [ADC_W-1:0] v_max_in = 12'd2300;
  logic [ADC_W-1:0] v_min_in = 12'd2100;
  logic [ADC_W-1:0] v_ave;
  logic             ave_valid;
  logic [TON_W-1:0] time_on;
  logic             locked;
  logic             band_err;

  int compared = 0;
  int mismatched = 0;

  int m_vave = 0;
  int m_ton = TON_INIT;
  int m_lock = 0;
  bit m_valid = 0;
  bit m_locked = 0;
  bit m_berr = 0;
  bit active = 0;
  bit decide_pending = 0;
  int settle_left = 0;
  int discard_left = 0;
  int win_q[$];

  average_regulator #(
    .ADC_W(ADC_W), .TON_W(TON_W), .LOG2_N(LOG2_N), .SETTLE_CYC(SETTLE_CYC),
    .DISCARD(DISCARD), .STEP(STEP), .TON_INIT(TON_INIT), .TON_MIN(TON_MIN),
    .TON_MAX(TON_MAX), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_1M(clk_1M), .rst_n(rst_n), .en(en), .sample_valid(sample_valid),
    .v_in(v_in), .v_max_in(v_max_in), .v_min_in(v_min_in), .v_ave(v_ave),
    .ave_valid(ave_valid), .time_on(time_on), .locked(locked), .band_err(band_err)
  );

  always #500 clk_1M = ~clk_1M;

  // Decision on a complete window: plain integer mean and band rules
  function automatic void model_decide();
    int total = 0;
    int avg;
    foreach (win_q[i]) total += win_q[i];
    avg = total / N;
    m_vave = avg;
    m_valid = 1;
    if (int'(v_min_in) > int'(v_max_in)) begin
      m_berr = 1; m_lock = 0; m_locked = 0;
    end else begin
      m_berr = 0;
      if (avg < int'(v_min_in)) begin
        m_ton = (m_ton + STEP > TON_MAX) ? TON_MAX : m_ton + STEP;
        m_lock = 0; m_locked = 0;
      end else if (avg > int'(v_max_in)) begin
        m_ton = (m_ton - STEP < TON_MIN) ? TON_MIN : m_ton - STEP;
        m_lock = 0; m_locked = 0;
      end else begin
        if (m_lock < LOCK_CNT) m_lock++;
        m_locked = (m_lock == LOCK_CNT);
      end
    end
    win_q.delete();
    discard_left = DISCARD;
    decide_pending = 0;
  endfunction

  always @(posedge clk_1M) begin
    m_valid = 0;
    if (!rst_n) begin
      m_vave = 0; m_ton = TON_INIT; m_lock = 0; m_locked = 0; m_berr = 0;
      active = 0; decide_pending = 0; win_q.delete();
    end else if (!en) begin
      active = 0; decide_pending = 0; win_q.delete(); m_lock = 0; m_locked = 0;
    end else if (!active) begin
      active = 1; settle_left = SETTLE_CYC; discard_left = DISCARD; win_q.delete();
    end else if (settle_left > 0) begin
      settle_left--;
    end else if (decide_pending) begin
      model_decide();
    end else if (sample_valid) begin
      if (discard_left > 0) discard_left--;
      else begin
        win_q.push_back(int'(v_in));
        if (win_q.size() == N) decide_pending = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1M);
    @(negedge clk_1M);
    chk("ave_valid", ave_valid, m_valid);
    chk("v_ave", v_ave, m_vave);
    chk("time_on", time_on, m_ton);
    chk("locked", locked, m_locked);
    chk("band_err", band_err, m_berr);
  endtask

  // Strobe every gap+1 cycles until k averages are seen on the DUT
  task automatic run_decisions(input int k, input int value, input int gap,
                               input bit rnd, output int strobes);
    int seen = 0;
    int cyc = 0;
    int since = gap;
    int budget = k * (DISCARD + N + 1) * (gap + 1) + SETTLE_CYC + 50;
    strobes = 0;
    while (seen < k) begin
      if (cyc >= budget) begin
        chk("decision_timeout", seen, k);
        sample_valid = 1'b0;
        return;
      end
      sample_valid = (since >= gap);
      if (sample_valid) begin
        since = 0;
        strobes++;
      end else begin
        since++;
      end
      v_in = ADC_W'(rnd ? value + $urandom_range(0, 255) : value);
      step();
      cyc++;
      if (ave_valid) seen++;
    end
    sample_valid = 1'b0;
  endtask

  task automatic send_window(input int s0, input int s1, input int s2, input int s3, input int s4);
    int vals[5] = '{s0, s1, s2, s3, s4};
    foreach (vals[i]) begin
      sample_valid = 1'b1;
      v_in = ADC_W'(vals[i]);
      step();
      sample_valid = 1'b0;
      if (i < 4) step();
    end
    step();
    chk("window_ave_valid", ave_valid, 1);
  endtask

  initial begin
    int n;
    int ton_before;

    repeat (3) step();
    chk("reset_v_ave", v_ave, 0);
    chk("reset_ave_valid", ave_valid, 0);
    chk("reset_time_on", time_on, TON_INIT);
    chk("reset_locked", locked, 0);
    chk("reset_band_err", band_err, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] ramp up to upper clamp");
    en = 1'b1;
    run_decisions(1, 2000, 0, 0, n);
    chk("first_avg_latency", n, FIRST_AVG_LATENCY);
    chk("first_v_ave", v_ave, 2000);
    chk("first_time_on", time_on, TON_INIT + 1);
    run_decisions(15, 2000, 0, 0, n);
    chk("upper_clamp", time_on, TON_MAX);

    $display("[TB] ramp down to lower clamp");
    run_decisions(449, 3000, 0, 0, n);
    chk("one_above_min", time_on, TON_MIN + 1);
    run_decisions(3, 3000, 0, 0, n);
    chk("lower_clamp", time_on, TON_MIN);

    $display("[TB] in-band lock");
    for (int w = 1; w <= LOCK_CNT; w++) begin
      send_window(0, 2200, 2201, 2202, 2203);
      chk("inband_v_ave", v_ave, 2201);
      if (w == LOCK_CNT - 1) chk("not_locked_yet", locked, 0);
    end
    chk("locked_after_8", locked, 1);
    chk("inband_time_on", time_on, TON_MIN);
    send_window(0, 2500, 2500, 2500, 2500);
    chk("unlock_v_ave", v_ave, 2500);
    chk("unlock", locked, 0);

    $display("[TB] inverted band");
    v_min_in = 12'd2300; v_max_in = 12'd2100;
    send_window(0, 2000, 2000, 2000, 2000);
    chk("band_err_set", band_err, 1);
    chk("band_err_time_on", time_on, TON_MIN);
    v_min_in = 12'd2100; v_max_in = 12'd2300;
    send_window(0, 2200, 2200, 2200, 2200);
    chk("band_err_clear", band_err, 0);

    $display("[TB] sparse strobes");
    for (int i = 0; i < 3; i++) begin
      run_decisions(1, 2150, 6, 1, n);
      chk("strobes_per_avg", n, DISCARD + N);
    end

    $display("[TB] enable drop during accumulation");
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; v_in = 12'd4000; step();
    end
    ton_before = m_ton;
    sample_valid = 1'b0; en = 1'b0;
    repeat (4) step();
    chk("idle_time_on_kept", time_on, ton_before);
    en = 1'b1;
    run_decisions(1, 1000, 0, 0, n);
    chk("reenable_latency", n, FIRST_AVG_LATENCY);
    chk("reenable_v_ave", v_ave, 1000);
    chk("reenable_time_on", time_on, ton_before + STEP);

    $display("[TB] random phase");
    for (int c = 0; c < 6000; c++) begin
      if (c % 300 == 0) begin
        v_min_in = ADC_W'(2000 + $urandom_range(0, 200));
        v_max_in = ADC_W'(int'(v_min_in) + $urandom_range(0, 300));
        if ($urandom_range(0, 9) == 0) begin
          v_max_in = ADC_W'(int'(v_min_in) - 1 - $urandom_range(0, 100));
        end
      end
      if (en && $urandom_range(0, 599) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      rst_n = ($urandom_range(0, 1999) != 0);
      sample_valid = ($urandom_range(0, 1) == 1);
      v_in = ADC_W'(1900 + $urandom_range(0, 500));
      step();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
